four_bit_adder: RTL and testbench

- Registered ripple-carry adder: S = A + B + Cin, with carry-out, signed-overflow and zero flags.
- Built from a chain of WIDTH one-bit full-adder cells; sum and flags are captured in output registers.
- Used as an arithmetic leaf in datapath exercises, driven by a simple valid-qualified operand interface.

---
 rtl/four_bit_adder.sv | 107 ++++++++++
 tb/tb_four_bit_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/four_bit_adder.sv
// ---------------------------------------------------------------------------
// four_bit_adder
//   Registered ripple-carry adder: {Cout, S} = A + B + Cin, with signed
//   overflow (V) and zero (Z) flags. The combinational datapath is a chain
//   of WIDTH one-bit full-adder cells. Sum and flags live in output
//   registers that only update when an operand set is marked valid.
//
//   Optional build macro: FOURADDER_IN_REG_EN
//     Defined   -> A/B/Cin/IN_VALID are first captured in an input stage,
//                  so latency is 2 cycles. Throughput stays one per cycle.
//     Undefined -> no input stage, so latency is 1 cycle.
//
// Parameters
//   WIDTH      operand and sum width in bits (2..32)
//
// Ports
//   CLK        rising-edge clock
//   RST_N      asynchronous active-low reset
//   IN_VALID   A/B/Cin are valid this cycle
//   A, B       operands (unsigned or two's complement)
//   Cin        carry-in
//   OUT_VALID  S/Cout/V/Z hold a new result this cycle
//   S          sum modulo 2^WIDTH
//   Cout       unsigned carry-out of the MSB
//   V          signed overflow (carry into MSB ^ carry out of MSB)
//   Z          registered sum is zero
// ---------------------------------------------------------------------------
module four_bit_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z
);

    logic             op_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;

`ifdef FOURADDER_IN_REG_EN
    // Operands are only loaded on a valid cycle, so unknown operand values
    // presented while IN_VALID is low never reach the adder.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_cin   <= 1'b0;
        end else begin
            op_valid <= IN_VALID;
            if (IN_VALID) begin
                op_a   <= A;
                op_b   <= B;
                op_cin <= Cin;
            end
        end
    end
`else
    assign op_valid = IN_VALID;
    assign op_a     = A;
    assign op_b     = B;
    assign op_cin   = Cin;
`endif

    // Ripple chain: carry[i] is the carry into cell i, and carry[WIDTH] is
    // the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = op_cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]     = op_a[i] ^ op_b[i] ^ carry[i];
            carry[i+1] = (op_a[i] & op_b[i]) | (op_a[i] & carry[i]) | (op_b[i] & carry[i]);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
        end else begin
            OUT_VALID <= op_valid;
            if (op_valid) begin
                S    <= sum;
                Cout <= carry[WIDTH];
                V    <= carry[WIDTH] ^ carry[WIDTH-1];
                Z    <= (sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_four_bit_adder.sv
// ---------------------------------------------------------------------------
// tb_four_bit_adder
//   Self-checking bench for four_bit_adder (WIDTH = 4). A reference model
//   computes results with integer arithmetic. It keeps a queue of in-flight
//   operand sets whose depth matches the build's latency (FOURADDER_IN_REG_EN
//   selects 2 cycles, otherwise 1).
// ---------------------------------------------------------------------------
module tb_four_bit_adder;

`ifdef FOURADDER_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       IN_VALID = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       Cin = 1'b0;
    logic       OUT_VALID;
    logic [3:0] S;
    logic       Cout;
    logic       V;
    logic       Z;

    four_bit_adder #(.WIDTH(4)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .OUT_VALID (OUT_VALID),
        .S         (S),
        .Cout      (Cout),
        .V         (V),
        .Z         (Z)
    );

    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic       vld;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
    } op_t;

    op_t        pipe[$];
    logic       m_ov, m_cout, m_v, m_z;
    logic [3:0] m_s;
    logic [7:0] exp;   // {OUT_VALID, Cout, V, Z, S} expected now

    task automatic model_reset();
        op_t idle;
        idle.vld = 1'b0; idle.a = '0; idle.b = '0; idle.cin = 1'b0;
        pipe.delete();
        for (int i = 0; i < LAT - 1; i++) pipe.push_back(idle);
        m_ov = 1'b0; m_cout = 1'b0; m_v = 1'b0; m_z = 1'b0; m_s = '0;
        exp = '0;
    endtask

    // Drive one cycle of inputs, wait for the edge, and advance the model.
    task automatic step(input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic vld);
        op_t         op;
        int unsigned u;
        int          sg;
        A = a; B = b; Cin = cin; IN_VALID = vld;
        @(posedge CLK);
        #1;
        op.vld = vld; op.a = a; op.b = b; op.cin = cin;
        pipe.push_back(op);
        op = pipe.pop_front();
        if (op.vld) begin
            u      = int'(op.a) + int'(op.b) + int'(op.cin);
            sg     = int'($signed(op.a)) + int'($signed(op.b)) + int'(op.cin);
            m_s    = u[3:0];
            m_cout = u[4];
            m_v    = (sg > 7) || (sg < -8);
            m_z    = (m_s == 4'd0);
            m_ov   = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
        exp = {m_ov, m_cout, m_v, m_z, m_s};
    endtask

    task automatic test_reset();
        total++;
        if ({OUT_VALID, Cout, V, Z, S} !== 8'h00)
            $display("FAIL reset_initial got %b exp %b", {OUT_VALID, Cout, V, Z, S}, 8'h00);
        else passed++;
        #2 RST_N = 1'b1;
        model_reset();
        step(4'd7, 4'd5, 1'b1, 1'b1);
        for (int i = 0; i < LAT - 1; i++) step(4'd0, 4'd0, 1'b0, 1'b0);
        total++;
        if ({OUT_VALID, Cout, V, Z, S} !== exp)
            $display("FAIL pre_reset_result got %b exp %b", {OUT_VALID, Cout, V, Z, S}, exp);
        else passed++;
        // Reset asserted mid-cycle while an operand set is valid.
        A = 4'd1; B = 4'd3; Cin = 1'b0; IN_VALID = 1'b1;
        #3 RST_N = 1'b0;
        #1;
        total++;
        if ({OUT_VALID, Cout, V, Z, S} !== 8'h00)
            $display("FAIL reset_async got %b exp %b", {OUT_VALID, Cout, V, Z, S}, 8'h00);
        else passed++;
        @(posedge CLK);
        #1;
        total++;
        if ({OUT_VALID, Cout, V, Z, S} !== 8'h00)
            $display("FAIL reset_held got %b exp %b", {OUT_VALID, Cout, V, Z, S}, 8'h00);
        else passed++;
        #2 RST_N = 1'b1;
        model_reset();
        step(4'd1, 4'd3, 1'b0, 1'b1);
        for (int i = 0; i < LAT - 1; i++) step(4'd0, 4'd0, 1'b0, 1'b0);
        total++;
        if ({OUT_VALID, S, Cout} !== {1'b1, 4'd4, 1'b0})
            $display("FAIL first_after_reset got v=%b s=%0d c=%b exp v=1 s=4 c=0", OUT_VALID, S, Cout);
        else passed++;
        total++;
        if ({OUT_VALID, Cout, V, Z, S} !== exp)
            $display("FAIL first_after_reset_model got %b exp %b", {OUT_VALID, Cout, V, Z, S}, exp);
        else passed++;
    endtask

    // Back-to-back sweep. Results are collected as they emerge and compared
    // with hand-computed constants and with the model.
    task automatic test_sweep(input logic cin);
        logic [3:0] ta[4], tb[4], ts[4];
        logic       tc[4], tv[4], tz[4];
        logic [6:0] got[$];
        int         n;
        if (cin) begin
            ta = '{4'd1, 4'd2, 4'd4, 4'd8};  tb = '{4'd3, 4'd6, 4'd12, 4'd9};
            ts = '{4'd5, 4'd9, 4'd1, 4'd2};  tc = '{1'b0, 1'b0, 1'b1, 1'b1};
            tv = '{1'b0, 1'b1, 1'b0, 1'b1};  tz = '{1'b0, 1'b0, 1'b0, 1'b0};
            n  = 4;
        end else begin
            ta = '{4'd2, 4'd4, 4'd8, 4'd0};  tb = '{4'd6, 4'd12, 4'd9, 4'd0};
            ts = '{4'd8, 4'd0, 4'd1, 4'd0};  tc = '{1'b0, 1'b1, 1'b1, 1'b0};
            tv = '{1'b1, 1'b0, 1'b1, 1'b0};  tz = '{1'b0, 1'b1, 1'b0, 1'b0};
            n  = 3;
        end
        for (int i = 0; i < n + LAT - 1; i++) begin
            if (i < n) step(ta[i], tb[i], cin, 1'b1);
            else       step(4'd0, 4'd0, 1'b0, 1'b0);
            total++;
            if ({OUT_VALID, Cout, V, Z, S} !== exp)
                $display("FAIL sweep_cin%0d_cycle%0d got %b exp %b", cin, i, {OUT_VALID, Cout, V, Z, S}, exp);
            else passed++;
            if (OUT_VALID === 1'b1) got.push_back({Cout, V, Z, S});
        end
        total++;
        if (got.size() != n)
            $display("FAIL sweep_cin%0d_count got %0d exp %0d", cin, got.size(), n);
        else passed++;
        for (int i = 0; i < n && i < got.size(); i++) begin
            total++;
            if (got[i] !== {tc[i], tv[i], tz[i], ts[i]})
                $display("FAIL sweep_cin%0d_result%0d got %b exp %b", cin, i, got[i], {tc[i], tv[i], tz[i], ts[i]});
            else passed++;
        end
    endtask

    task automatic test_hold();
        step(4'd1, 4'd3, 1'b1, 1'b1);
        for (int i = 0; i < LAT - 1; i++) step(4'd0, 4'd0, 1'b0, 1'b0);
        total++;
        if ({OUT_VALID, S} !== {1'b1, 4'd5})
            $display("FAIL hold_setup got v=%b s=%0d exp v=1 s=5", OUT_VALID, S);
        else passed++;
        step(4'd15, 4'd15, 1'b1, 1'b0);
        step(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
        step(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
        total++;
        if ({OUT_VALID, S, Cout, V, Z} !== {1'b0, 4'd5, 1'b0, 1'b0, 1'b0})
            $display("FAIL hold got v=%b s=%0d c=%b v=%b z=%b exp v=0 s=5 c=0 v=0 z=0", OUT_VALID, S, Cout, V, Z);
        else passed++;
        total++;
        if ({OUT_VALID, Cout, V, Z, S} !== exp)
            $display("FAIL hold_model got %b exp %b", {OUT_VALID, Cout, V, Z, S}, exp);
        else passed++;
    endtask

    task automatic test_wrap();
        step(4'd15, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < LAT - 1; i++) step(4'd0, 4'd0, 1'b0, 1'b0);
        total++;
        if ({OUT_VALID, S, Cout, Z} !== {1'b1, 4'd0, 1'b1, 1'b1})
            $display("FAIL wrap got v=%b s=%0d c=%b z=%b exp v=1 s=0 c=1 z=1", OUT_VALID, S, Cout, Z);
        else passed++;
    endtask

    task automatic test_exhaustive();
        logic [8:0] v;
        for (int k = 0; k < 512 + LAT - 1; k++) begin
            v = 9'(k);
            if (k < 512) step(v[8:5], v[4:1], v[0], 1'b1);
            else         step(4'd0, 4'd0, 1'b0, 1'b0);
            total++;
            if ({OUT_VALID, Cout, V, Z, S} !== exp)
                $display("FAIL exhaustive_%0d got %b exp %b", k, {OUT_VALID, Cout, V, Z, S}, exp);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            step(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
            total++;
            if ({OUT_VALID, Cout, V, Z, S} !== exp)
                $display("FAIL random_%0d got %b exp %b", k, {OUT_VALID, Cout, V, Z, S}, exp);
            else passed++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        test_reset();
        test_sweep(1'b0);
        test_sweep(1'b1);
        test_hold();
        test_wrap();
        test_exhaustive();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
